seq_divider128: RTL
===================

Name: seq_divider128

Overview:
- Multi-cycle unsigned restoring divider; the inverse of the 64x64 Karatsuba multiplier.
- Takes a 2N-bit dividend (a product word) and an N-bit divisor, and returns an N-bit quotient and an N-bit remainder.
- Computes one quotient bit per clock behind a valid/ready handshake.
- Used to check or undo products emitted by the multiplier datapath.

Parameters:
- N, 64, divisor/quotient/remainder width; dividend is 2N bits.
- CW, 7, iteration counter width; must satisfy 2^CW > N.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- dividend  input  2N  unsigned dividend.
- divisor  input  N  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  N  unsigned quotient.
- remainder  output  N  unsigned remainder.
- div_by_zero  output  1  divisor was zero.
- overflow  output  1  quotient does not fit in N bits.

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - state = IDLE.
  - in_ready=1, out_valid=0.
  - quotient, remainder, div_by_zero and overflow all = 0.
  - Any operation in flight is aborted; no result is produced for it.
- States and in_ready:
  - States are IDLE, CALC and DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE, on in_valid & in_ready (the accept edge):
  - Latch the divisor into D.
  - If divisor==0: div_by_zero=1, overflow=0, quotient = all ones, remainder = dividend[2N-1:N]. Go to DONE.
  - Else if dividend[2N-1:N] >= divisor: overflow=1, div_by_zero=0, quotient = all ones, remainder = dividend[2N-1:N]. Go to DONE.
  - Else: R = dividend[2N-1:N], Q = dividend[N-1:0], cnt = N-1, both flags = 0. Go to CALC.
- CALC, each cycle:
  - Form the N+1-bit value S = {R, Q[N-1]} and shift Q left by 1.
  - T = S - {1'b0, D}, computed at N+1 bits.
  - If T is non-negative (no borrow): R = T[N-1:0] and the new Q[0] = 1.
  - Otherwise: R = S[N-1:0] and the new Q[0] = 0.
  - If cnt==0, go to DONE with quotient=Q and remainder=R; otherwise cnt decrements.
- Latency:
  - Accept in cycle 0 → CALC in cycles 1..N → out_valid high from cycle N+1.
  - Error cases: out_valid high from cycle 1.
- DONE:
  - Outputs and flags are held stable while out_valid & !out_ready.
  - On out_ready, go to IDLE at the next edge.
  - Outputs keep their values after leaving DONE, until the next result is loaded.
  - out_valid drops, in_ready rises.
- Minimum back-to-back period is N+2 cycles.
- in_valid while not in IDLE is ignored; operand inputs are sampled only on the accept edge.
- out_ready outside DONE is ignored.
- Flag precedence: div_by_zero wins over overflow; the two are never set together.
- Postcondition when no flag is set: dividend == quotient*divisor + remainder, and remainder < divisor.

Test Plan:
- Exact division:
  - dividend = 64'h0123456789ABCDEF * 64'hFEDCBA9876543210 (bench-computed), divisor = 64'hFEDCBA9876543210.
  - Required: quotient = 64'h0123456789ABCDEF, remainder = 0, flags 0, out_valid first seen in cycle 65. Repeat with dividend+5 → remainder = 5.
- Boundary maximum:
  - dividend = 128'hFFFFFFFFFFFFFFFE_0000000000000001, divisor = 64'hFFFFFFFFFFFFFFFF.
  - Required: quotient = 64'hFFFFFFFFFFFFFFFF, remainder = 0.
  - Also dividend = 128'h0000000000000000_FFFFFFFFFFFFFFFF with the same divisor → quotient = 1, remainder = 0.
- Error paths:
  - divisor = 0, dividend = 128'h5 → div_by_zero=1, overflow=0, quotient = all ones, remainder = 0, out_valid in cycle 1.
  - dividend = 128'h1_0000000000000000, divisor = 1 → overflow=1, div_by_zero=0, remainder = 1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid.
  - Required: quotient, remainder and flags unchanged; in_ready=0; in_valid pulses ignored.
  - On out_ready=1: in_ready=1 next cycle; a new op is accepted and its result is correct.
- Reset mid-operation:
  - Assert rst_n=0 in cycle 30 of CALC.
  - Required: out_valid=0, in_ready=1 and all outputs 0 immediately (asynchronous).
  - After release, 100/7 (divisor = 7) → quotient = 14, remainder = 2.

Source files
------------

// File: rtl/seq_divider128.sv
// Multi-cycle unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, valid/ready handshake on both sides.
module seq_divider128 #(
  parameter int N  = 64,
  parameter int CW = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [N-1:0]  d;
  logic [N-1:0]  r;
  logic [N-1:0]  q;
  logic [CW-1:0] cnt;

  logic [N:0]    s;
  logic [N:0]    t;
  logic [N-1:0]  r_nxt;
  logic [N-1:0]  q_nxt;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;

  assign hi        = dividend[2*N-1:N];
  assign lo        = dividend[N-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One restoring step: R < D always holds, so a non-borrowing T fits in N bits.
  always_comb begin
    s = {r, q[N-1]};
    t = s - {1'b0, d};
    if (!t[N]) begin
      r_nxt = t[N-1:0];
      q_nxt = {q[N-2:0], 1'b1};
    end else begin
      r_nxt = s[N-1:0];
      q_nxt = {q[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      d           <= '0;
      r           <= '0;
      q           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d <= divisor;
            if (divisor == '0) begin
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              quotient    <= '1;
              remainder   <= hi;
              state       <= DONE;
            end else if (hi >= divisor) begin
              // Quotient would need more than N bits.
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              quotient    <= '1;
              remainder   <= hi;
              state       <= DONE;
            end else begin
              r           <= hi;
              q           <= lo;
              cnt         <= CW'(N - 1);
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          r <= r_nxt;
          q <= q_nxt;
          if (cnt == '0) begin
            quotient  <= q_nxt;
            remainder <= r_nxt;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
